ex_operand_stage: RTL and testbench

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

---
 rtl/ex_operand_stage.sv | 130 +++++++++++++
 tb/tb_ex_operand_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//   ID -> EX pipeline register with operand forwarding and hazard detection.
//   The EX-stage writer is this stage's own registered state (ex_rd,
//   ex_reg_write, ex_mem_read, ex_valid); its ALU result comes back in on
//   ex_fwd_data. The MEM-stage writer is described by mem_wr/mem_rd/mem_fwd_data.
//
//   Ports
//     clk, reset            clock, synchronous active-high reset
//     id_*                  decoded instruction fields from ID
//     ex_fwd_data           ALU result of the instruction currently in EX
//     mem_wr, mem_rd        MEM-stage writer (reg_write, destination)
//     mem_mem_read          MEM-stage instruction is a load
//     mem_fwd_data          MEM-stage result / load data
//     flush                 branch taken, kill the instruction in ID
//     alu_a, alu_b          registered ALU operands
//     alu_operation, ex_rd, ex_reg_write, ex_mem_read, ex_valid   EX registers
//     stall                 combinational, hold PC and IF/ID this cycle
//     stall_count           saturating count of stall cycles
//
//   Build option
//     FORWARDING_EN  defined   : EX/MEM bypass; only load-use in EX stalls.
//                    undefined : no bypass; any EX or MEM match stalls.

module ex_operand_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [DATA_W-1:0] id_rs_val,
    input  logic [DATA_W-1:0] id_rt_val,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_use_imm,
    input  logic [5:0]        id_operation,
    input  logic [4:0]        id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [DATA_W-1:0] ex_fwd_data,
    input  logic              mem_wr,
    input  logic [4:0]        mem_rd,
    input  logic              mem_mem_read,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic              flush,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [5:0]        alu_operation,
    output logic [4:0]        ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_valid,
    output logic              stall,
    output logic [15:0]       stall_count
);

    localparam logic [5:0] NOP_OP = 6'b111111;

    logic              ex_writes;
    logic              ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic              hazard, bubble;
    logic [DATA_W-1:0] opnd_a, opnd_b;

    // rt is only a source when B comes from the register file.
    assign ex_writes  = ex_valid && ex_reg_write;
    assign ex_hit_rs  = (id_rs != 5'd0) && ex_writes && (ex_rd == id_rs);
    assign ex_hit_rt  = !id_use_imm && (id_rt != 5'd0) && ex_writes && (ex_rd == id_rt);
    assign mem_hit_rs = (id_rs != 5'd0) && mem_wr && (mem_rd == id_rs);
    assign mem_hit_rt = !id_use_imm && (id_rt != 5'd0) && mem_wr && (mem_rd == id_rt);

`ifdef FORWARDING_EN
    // Only a load still in EX lacks its data; a load in MEM already has it,
    // so mem_mem_read does not change the bypass decision.
    logic unused_mem_load;
    assign unused_mem_load = mem_mem_read;

    assign hazard = ex_mem_read && (ex_hit_rs || ex_hit_rt);
    assign opnd_a = ex_hit_rs  ? ex_fwd_data  :
                    mem_hit_rs ? mem_fwd_data : id_rs_val;
    assign opnd_b = ex_hit_rt  ? ex_fwd_data  :
                    mem_hit_rt ? mem_fwd_data : id_rt_val;
`else
    // No bypass: wait until the writer reaches WB, where the write-first
    // register file makes the value visible on id_*_val.
    logic unused_fwd;
    assign unused_fwd = ^{ex_fwd_data, mem_fwd_data, mem_mem_read};

    assign hazard = ex_hit_rs || ex_hit_rt || mem_hit_rs || mem_hit_rt;
    assign opnd_a = id_rs_val;
    assign opnd_b = id_rt_val;
`endif

    assign stall  = !reset && id_valid && !flush && hazard;
    assign bubble = !id_valid || flush || stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a         <= '0;
            alu_b         <= '0;
            alu_operation <= NOP_OP;
            ex_rd         <= 5'd0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_valid      <= 1'b0;
            stall_count   <= 16'd0;
        end else begin
            if (stall && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 16'd1;

            if (bubble) begin
                alu_a         <= '0;
                alu_b         <= '0;
                alu_operation <= NOP_OP;
                ex_rd         <= 5'd0;
                ex_reg_write  <= 1'b0;
                ex_mem_read   <= 1'b0;
                ex_valid      <= 1'b0;
            end else begin
                alu_a         <= opnd_a;
                alu_b         <= id_use_imm ? id_imm : opnd_b;
                alu_operation <= id_operation;
                ex_rd         <= id_rd;
                ex_reg_write  <= id_reg_write;
                ex_mem_read   <= id_mem_read;
                ex_valid      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

    localparam int DATA_W = 32;
    localparam logic [5:0] NOP_OP = 6'b111111;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic [DATA_W-1:0] id_rs_val, id_rt_val, id_imm;
    logic              id_use_imm;
    logic [5:0]        id_operation;
    logic              id_reg_write, id_mem_read;
    logic [DATA_W-1:0] ex_fwd_data;
    logic              mem_wr;
    logic [4:0]        mem_rd;
    logic              mem_mem_read;
    logic [DATA_W-1:0] mem_fwd_data;
    logic              flush;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [5:0]        alu_operation;
    logic [4:0]        ex_rd;
    logic              ex_reg_write, ex_mem_read, ex_valid;
    logic              stall;
    logic [15:0]       stall_count;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_sc;

    ex_operand_stage #(.DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
        .id_imm(id_imm), .id_use_imm(id_use_imm),
        .id_operation(id_operation), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_fwd_data(ex_fwd_data),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_mem_read(mem_mem_read),
        .mem_fwd_data(mem_fwd_data), .flush(flush),
        .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_valid(ex_valid), .stall(stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, "_rw"},    {31'd0, ex_reg_write}, 32'd0);
        chk({tag, "_mr"},    {31'd0, ex_mem_read}, 32'd0);
        chk({tag, "_op"},    {26'd0, alu_operation}, {26'd0, NOP_OP});
        chk({tag, "_a"},     alu_a, 32'd0);
        chk({tag, "_b"},     alu_b, 32'd0);
    endtask

    initial begin
        reset = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
        id_rs_val = '0; id_rt_val = '0; id_imm = '0; id_use_imm = 1'b0;
        id_operation = '0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        ex_fwd_data = '0; mem_wr = 1'b0; mem_rd = '0; mem_mem_read = 1'b0;
        mem_fwd_data = '0; flush = 1'b0;
        exp_sc = 16'd0;
        #1;

        // reset with a live instruction presented
        id_valid = 1'b1; id_rs = 5'd1; id_rs_val = 32'h55; id_rd = 5'd1;
        id_reg_write = 1'b1; id_operation = 6'h20;
        #1 chk("rst_stall", {31'd0, stall}, 32'd0);
        tick();
        chk_bubble("rst");
        chk("rst_rd", {27'd0, ex_rd}, 32'd0);
        chk("rst_sc", {16'd0, stall_count}, 32'd0);

        // plain capture, writer of r2
        reset = 1'b0;
        id_rs = 5'd1; id_rt = 5'd3; id_rs_val = 32'h11; id_rt_val = 32'h22;
        id_rd = 5'd2; id_reg_write = 1'b1; id_mem_read = 1'b0; id_operation = 6'h20;
        #1 chk("cap_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("cap_a", alu_a, 32'h11);
        chk("cap_b", alu_b, 32'h22);
        chk("cap_op", {26'd0, alu_operation}, 32'h20);
        chk("cap_rd", {27'd0, ex_rd}, 32'd2);
        chk("cap_valid", {31'd0, ex_valid}, 32'd1);
        chk("cap_rw", {31'd0, ex_reg_write}, 32'd1);

`ifdef FORWARDING_EN
        // EX forward to A
        id_rs = 5'd2; id_rt = 5'd0; id_use_imm = 1'b0; id_rs_val = 32'h0; id_rt_val = 32'h0;
        ex_fwd_data = 32'h10; id_rd = 5'd5; id_reg_write = 1'b1;
        #1 chk("exfwd_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("exfwd_a", alu_a, 32'h10);

        // EX beats MEM for the same register
        id_rs = 5'd0; id_rt = 5'd5; id_rt_val = 32'h1;
        ex_fwd_data = 32'h7; mem_wr = 1'b1; mem_rd = 5'd5; mem_fwd_data = 32'h9;
        id_rd = 5'd4; id_mem_read = 1'b1;
        tick();
        chk("prio_b", alu_b, 32'h7);

        // load-use: lw r4 in EX
        id_rs = 5'd4; id_rt = 5'd0; id_rs_val = 32'h3; mem_wr = 1'b0;
        ex_fwd_data = 32'hDEAD; id_rd = 5'd8; id_mem_read = 1'b1;
        #1 chk("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        exp_sc = 16'd1;
        chk_bubble("lu_bub");
        chk("lu_sc", {16'd0, stall_count}, {16'd0, exp_sc});
        mem_wr = 1'b1; mem_rd = 5'd4; mem_mem_read = 1'b1; mem_fwd_data = 32'h44;
        #1 chk("lu_mem_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("lu_mem_a", alu_a, 32'h44);
        chk("lu_mem_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_mem_sc", {16'd0, stall_count}, {16'd0, exp_sc});

        // load-use hazard killed by flush
        id_rs = 5'd8; mem_wr = 1'b0; mem_mem_read = 1'b0; flush = 1'b1;
        #1 chk("luf_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("luf_valid", {31'd0, ex_valid}, 32'd0);
        chk("luf_sc", {16'd0, stall_count}, {16'd0, exp_sc});
        flush = 1'b0;
`else
        // no bypass: EX writer of r2 -> two stall cycles
        id_rs = 5'd2; id_rt = 5'd0; id_use_imm = 1'b1; id_imm = 32'h5;
        id_rs_val = 32'hAA; id_rd = 5'd6; id_reg_write = 1'b1; id_operation = 6'h21;
        #1 chk("nf_stall1", {31'd0, stall}, 32'd1);
        tick();
        chk_bubble("nf_bub1");
        chk("nf_sc1", {16'd0, stall_count}, 32'd1);
        mem_wr = 1'b1; mem_rd = 5'd2; mem_fwd_data = 32'hCC;
        #1 chk("nf_stall2", {31'd0, stall}, 32'd1);
        tick();
        chk("nf_valid2", {31'd0, ex_valid}, 32'd0);
        chk("nf_sc2", {16'd0, stall_count}, 32'd2);
        mem_wr = 1'b0; id_rs_val = 32'hBB;
        #1 chk("nf_stall3", {31'd0, stall}, 32'd0);
        tick();
        exp_sc = 16'd2;
        chk("nf_a", alu_a, 32'hBB);
        chk("nf_b", alu_b, 32'h5);
        chk("nf_rd", {27'd0, ex_rd}, 32'd6);
        chk("nf_valid3", {31'd0, ex_valid}, 32'd1);
        chk("nf_sc3", {16'd0, stall_count}, {16'd0, exp_sc});
`endif

        // immediate B ignores rt hazard; next instruction writes r0
        id_rs = 5'd0; id_rt = 5'd6; id_use_imm = 1'b1; id_imm = 32'hFFFF_FFF0;
        id_rs_val = 32'h0; id_rt_val = 32'h123; mem_wr = 1'b0;
        id_rd = 5'd0; id_reg_write = 1'b1; id_mem_read = 1'b0; id_operation = 6'h08;
        #1 chk("imm_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("imm_b", alu_b, 32'hFFFF_FFF0);
        chk("imm_a", alu_a, 32'h0);

        // r0 is never forwarded or stalled
        id_rs = 5'd0; id_rt = 5'd0; id_use_imm = 1'b0; id_rs_val = 32'h0; id_rt_val = 32'h0;
        ex_fwd_data = 32'hFFFF; mem_wr = 1'b1; mem_rd = 5'd0; mem_fwd_data = 32'hFFFF;
        id_rd = 5'd7; id_reg_write = 1'b1; id_mem_read = 1'b1; id_operation = 6'h23;
        #1 chk("r0_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("r0_a", alu_a, 32'h0);
        chk("r0_b", alu_b, 32'h0);
        chk("r0_mr", {31'd0, ex_mem_read}, 32'd1);

        // id_valid=0 with a hazard pattern
        mem_wr = 1'b0; id_valid = 1'b0; id_rs = 5'd7;
        #1 chk("iv_stall", {31'd0, stall}, 32'd0);
        tick();
        chk_bubble("iv_bub");

        // load r7 into EX, then flush the dependent instruction
        id_valid = 1'b1; id_rs = 5'd0; id_use_imm = 1'b1; id_imm = 32'h4;
        id_rd = 5'd7; id_reg_write = 1'b1; id_mem_read = 1'b1;
        tick();
        chk("ld_mr", {31'd0, ex_mem_read}, 32'd1);
        id_rs = 5'd7; id_rd = 5'd9; id_mem_read = 1'b0; flush = 1'b1;
        #1 chk("fl_stall", {31'd0, stall}, 32'd0);
        tick();
        chk_bubble("fl_bub");
        chk("fl_sc", {16'd0, stall_count}, {16'd0, exp_sc});
        flush = 1'b0;

        // reset arriving during a load-use stall
        id_rs = 5'd0; id_rd = 5'd7; id_mem_read = 1'b1;
        tick();
        id_rs = 5'd7; id_rs_val = 32'h77; id_imm = 32'h1; id_rd = 5'd9; id_mem_read = 1'b0;
        #1 chk("rs_stall", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        #1 chk("rs_stall_rst", {31'd0, stall}, 32'd0);
        tick();
        chk_bubble("rs_bub");
        chk("rs_rd", {27'd0, ex_rd}, 32'd0);
        chk("rs_sc", {16'd0, stall_count}, 32'd0);
        reset = 1'b0;
        #1 chk("rs_post_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("rs_post_a", alu_a, 32'h77);
        chk("rs_post_b", alu_b, 32'h1);
        chk("rs_post_valid", {31'd0, ex_valid}, 32'd1);
        chk("rs_post_rd", {27'd0, ex_rd}, 32'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
